// File: rtl/shift_in_pkg.sv
// Shared definitions for the serial link shifters: state encoding and the
// default word geometry, so the transmit and receive sides stay matched.
package shift_in_pkg;

    localparam int SHIFT_WIDTH  = 64;
    localparam int SHIFT_CWIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_in.sv
// Serial-in, parallel-out receiver: captures WIDTH bits LSB first and
// offers the completed word through a valid/ready handshake.
module shift_in
    import shift_in_pkg::*;
#(
    parameter int WIDTH  = SHIFT_WIDTH,
    parameter int CWIDTH = SHIFT_CWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              enable,
    input  logic              sin,
    output logic [WIDTH-1:0]  word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic [CWIDTH-1:0] bit_count,
    output logic              overrun
);

    if ((2 ** CWIDTH) < WIDTH) begin : g_cwidth_check
        $error("shift_in: CWIDTH too small to index WIDTH bits");
    end

    localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(WIDTH - 1);
    localparam logic [CWIDTH-1:0] ONE_IDX  = CWIDTH'(1);

    state_e             state_r;
    state_e             state_s;
    logic [WIDTH-1:0]   word_r;
    logic [WIDTH-1:0]   word_s;
    logic [CWIDTH-1:0]  bit_count_r;
    logic [CWIDTH-1:0]  bit_count_s;
    logic               overrun_r;
    logic               overrun_s;
    logic               word_valid_r;
    logic               busy_r;

    // Next-state and datapath update; start overrides handshake, which overrides enable.
    always_comb begin
        state_s     = state_r;
        word_s      = word_r;
        bit_count_s = bit_count_r;
        overrun_s   = overrun_r;
        if (start) begin
            state_s     = ST_SHIFT;
            word_s      = {WIDTH{1'b0}};
            bit_count_s = {CWIDTH{1'b0}};
            overrun_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (enable) begin
                        word_s[bit_count_r] = sin;
                        if (bit_count_r == LAST_IDX) begin
                            state_s     = ST_FULL;
                            bit_count_s = {CWIDTH{1'b0}};
                        end else begin
                            bit_count_s = bit_count_r + ONE_IDX;
                        end
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
                ST_FULL: begin
                    // A bit arriving in the acceptance cycle is dropped silently.
                    if (word_valid_r && word_ready) begin
                        state_s = ST_IDLE;
                    end else if (enable) begin
                        overrun_s = 1'b1;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    word_s      = {WIDTH{1'b0}};
                    bit_count_s = {CWIDTH{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            word_r       <= {WIDTH{1'b0}};
            bit_count_r  <= {CWIDTH{1'b0}};
            overrun_r    <= 1'b0;
            word_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            word_r       <= word_s;
            bit_count_r  <= bit_count_s;
            overrun_r    <= overrun_s;
            word_valid_r <= (state_s == ST_FULL);
            busy_r       <= (state_s == ST_SHIFT);
        end
    end

    assign word       = word_r;
    assign bit_count  = bit_count_r;
    assign overrun    = overrun_r;
    assign word_valid = word_valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_shift_in.sv
// Randomised and directed bench for shift_in (WIDTH=8) against a
// bit-queue reference model.
module tb_shift_in;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          enable;
    logic          sin;
    logic [W-1:0]  word;
    logic          word_valid;
    logic          word_ready;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          overrun;

    int n_cmp;
    int n_bad;

    // Reference model: captured bits held in a queue, word built arithmetically.
    bit     m_bits[$];
    int     m_word;
    bit     m_valid;
    bit     m_busy;
    bit     m_ovr;

    shift_in #(.WIDTH(W), .CWIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .enable     (enable),
        .sin        (sin),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .bit_count  (bit_count),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_word  = 0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step();
        if (start) begin
            m_bits.delete();
            m_word  = 0;
            m_busy  = 1'b1;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else if (m_valid) begin
            if (word_ready) m_valid = 1'b0;
            else if (enable) m_ovr = 1'b1;
        end else if (m_busy && enable) begin
            if (sin) m_word = m_word + (1 << m_bits.size());
            m_bits.push_back(sin);
            if (m_bits.size() == W) begin
                m_bits.delete();
                m_busy  = 1'b0;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check("word",       64'(word),       64'(m_word[W-1:0]));
        check("word_valid", 64'(word_valid), 64'(m_valid));
        check("busy",       64'(busy),       64'(m_busy));
        check("bit_count",  64'(bit_count),  64'(m_bits.size()));
        check("overrun",    64'(overrun),    64'(m_ovr));
    endtask

    task automatic cyc(input logic st, input logic en, input logic s, input logic rdy);
        start      = st;
        enable     = en;
        sin        = s;
        word_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [W-1:0] v, input int gap);
        for (int i = 0; i < W; i++) begin
            cyc(1'b0, 1'b1, v[i], 1'b0);
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        enable     = 1'b0;
        sin        = 1'b0;
        word_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Basic capture of A5.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'hA5, 0);
        check("a5_word",  64'(word), 64'h0A5);
        check("a5_valid", 64'(word_valid), 64'h1);

        // Hold FULL, enables while not accepted raise overrun.
        for (int i = 0; i < 5; i++) cyc(1'b0, (i == 1 || i == 3), 1'b1, 1'b0);
        check("ovr_word", 64'(word), 64'h0A5);
        check("ovr_flag", 64'(overrun), 64'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_sticky", 64'(overrun), 64'h1);

        // Same word with gaps between bits.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'hA5, 2);
        check("gap_word", 64'(word), 64'h0A5);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);

        // Restart mid-word discards the partial.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        send_word(8'h3C, 0);
        check("restart_word", 64'(word), 64'h03C);

        // Start together with acceptance.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("st_acc_busy",  64'(busy), 64'h1);
        check("st_acc_word",  64'(word), 64'h0);
        check("st_acc_valid", 64'(word_valid), 64'h0);

        // Async reset at bit 5, then enables in IDLE are ignored.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        async_reset();
        check("rst_word", 64'(word), 64'h0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("idle_word", 64'(word), 64'h0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
                1'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_in.md
Name: shift_in

Overview:
Serial-in, parallel-out shift register. It is the receiving end of the team's parallel-in/serial-out shifter.
- Collects WIDTH bits from a single serial line, one bit per enabled clock, LSB (bit index 0) first.
- Presents the completed word with a valid/ready handshake.
- Sits on the reader side of the ReaderWriter link, between the serial wire and the word-level consumer.

Parameters:
WIDTH, 64, word width in bits (bits captured per word)
CWIDTH, 6, bit-index counter width; 2**CWIDTH >= WIDTH is required, checked by an elaboration-time assertion

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  synchronous arm/restart: clear word and index, begin capture
enable  input  1  sample sin this cycle (one bit per enabled cycle)
sin  input  1  serial data in, bit 0 first
word  output  WIDTH  captured word; meaningful only while word_valid=1
word_valid  output  1  complete word available
word_ready  input  1  consumer accepts word when word_valid & word_ready
busy  output  1  1 while in SHIFT state
bit_count  output  CWIDTH  number of bits captured so far in current word
overrun  output  1  sticky: enable seen while in FULL (bit dropped)

Behaviour:
- Reset (reset_n=0, async, takes effect immediately): state=IDLE, word=0, bit_count=0, word_valid=0, busy=0, overrun=0.
- States: IDLE, SHIFT, FULL. Outputs are registered, with word_valid=(state==FULL) and busy=(state==SHIFT).
- Priority order each cycle: start > accept handshake > enable.
- IDLE:
  - enable is ignored and sin is not sampled.
  - start: word<=0, bit_count<=0, overrun<=0, go to SHIFT.
- SHIFT:
  - enable: word[bit_count]<=sin, bit_count<=bit_count+1.
  - enable when bit_count==WIDTH-1: store the last bit, go to FULL, bit_count<=0. No wrap to an extra bit.
  - The first word_valid=1 appears the cycle after the WIDTH-th enable.
  - enable=0: hold all state; gaps between bits are legal.
  - start mid-word: discard partial word, restart at index 0 with word cleared. The current-cycle enable/sin are ignored.
- FULL:
  - word is held stable while word_valid=1.
  - word_valid & word_ready: go to IDLE next cycle. word keeps its value until the next start.
  - enable while FULL and not accepted this cycle: overrun<=1, the bit is dropped, the word is not modified.
  - enable in the same cycle as acceptance: the bit is dropped, but overrun is not set.
  - start while FULL (with or without word_ready): the word is abandoned if not accepted. word_valid falls next cycle, word/bit_count are cleared, overrun is cleared, state goes to SHIFT.
- overrun is sticky; only reset_n or start clear it.
- bit_count never exceeds WIDTH-1; its arithmetic is CWIDTH-bit unsigned.
- sin is sampled only on cycles with enable=1 in SHIFT; it is don't-care otherwise.
- Async reset asserted mid-word or mid-handshake aborts everything: word_valid drops without completing the handshake.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_FULL=2'd2;
  - the default WIDTH/CWIDTH constants, so the transmit and receive shifters stay matched.
- No sub-module. The index counter and state register are small enough to stay inline.

Test Plan:
- WIDTH=8, CWIDTH=3: reset, start, 8 enables with sin=1,0,1,0,0,1,0,1 -> word=8'hA5, word_valid=1 the cycle after the 8th enable, bit_count=0, busy=0.
- Same stimulus with enable gaps (enable every 3rd cycle) -> word=8'hA5; bit_count steps 0..7 only on enabled cycles.
- word_valid=1 with word_ready=0 for 5 cycles, 2 enables with sin=1 -> word stays 8'hA5, overrun=1. Then word_ready=1 -> IDLE next cycle, overrun stays 1 until start.
- Start after 4 bits (sin=1,1,1,1), then 8 bits of 8'h3C -> word=8'h3C, with no residue from the discarded partial word.
- reset_n pulsed low at bit 5 -> word=0, bit_count=0, word_valid=0, busy=0 immediately, asynchronously. In IDLE, enables without start do not change the word.
- start in the same cycle as word_valid & word_ready -> next cycle state=SHIFT, word=0, word_valid=0, overrun=0.
